// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared constants, state encoding and address-wrap helper for the
// instruction-memory fetch sequencer.
package imem_fetch_sequencer_pkg;

  localparam int          IMEM_DEPTH = 256;
  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Word-align a byte address and fold it into the memory's byte range.
  function automatic logic [31:0] wrap_addr(input logic [31:0] a, input int depth);
    return a & (32'(depth * WORD_BYTES) - 32'd1) & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/imem_next_pc.sv
// Combinational next-PC selector: jump > branch > stall > sequential,
// with every result word-aligned and wrapped to the memory size.
module imem_next_pc
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  always_comb begin
    o_pc_plus4 = wrap_addr(i_pc + 32'd4, DEPTH);
    o_next_pc  = o_pc_plus4;
    if (i_jmp) begin
      o_next_pc = wrap_addr(i_jmp_target, DEPTH);
    end else if (i_br_taken) begin
      o_next_pc = wrap_addr(i_br_target, DEPTH);
    end else if (i_stall) begin
      o_next_pc = i_pc;
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Single-port instruction memory owner: LOAD phase fills memory from a host
// stream, RUN phase drives the fetch PC every cycle.
module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] RESET_PC = imem_fetch_sequencer_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reload,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        cpu_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        running,
  output logic        dbg_state
);

  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_wp;
  logic [31:0]   r_pc;
  logic [31:0]   w_next_pc;
  logic          w_load;
  logic          w_write;
  logic          w_done;

  // Handshake: a word transfers on any cycle where ld_valid && ld_ready;
  // ld_ready is high for the whole LOAD phase and never depends on ld_valid.
  // A reload in the same cycle cancels the transfer.
  assign w_load  = (r_state == ST_LOAD);
  assign w_write = ld_valid & w_load & ~reload;
  assign w_done  = w_write & (ld_last | (r_wp == AW'(DEPTH - 1)));

  imem_next_pc #(
    .DEPTH(DEPTH)
  ) u_next_pc (
    .i_pc        (r_pc),
    .i_stall     (cpu_stall),
    .i_br_taken  (br_taken),
    .i_br_target (br_target),
    .i_jmp       (jmp),
    .i_jmp_target(jmp_target),
    .o_pc_plus4  (pc_plus4),
    .o_next_pc   (w_next_pc)
  );

  always_comb begin
    w_next_state = r_state;
    ld_ready     = 1'b0;
    imem_we      = 1'b0;
    imem_addr    = r_pc;
    imem_wdata   = ld_data;
    fetch_valid  = 1'b0;
    running      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        ld_ready  = 1'b1;
        // Write strobe is masked while reset is held so nothing is written
        // before the sequencer is out of reset.
        imem_we   = w_write & rst_n;
        imem_addr = 32'({r_wp, 2'b00});
        if (w_done) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
        running     = 1'b1;
        if (reload) begin
          w_next_state = ST_LOAD;
        end
      end
      default: w_next_state = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_wp    <= '0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_pc <= RESET_PC;
        if (reload || w_done) begin
          r_wp <= '0;
        end else if (w_write) begin
          r_wp <= r_wp + 1'b1;
        end
      end else if (reload) begin
        r_pc <= RESET_PC;
        r_wp <= '0;
      end else begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign pc        = r_pc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer: vector table for load/run flow,
// plus hand sequences for full-memory load, PC wrap and async reset.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        reload;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        cpu_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        running;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  imem_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reload     (reload),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .cpu_stall  (cpu_stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_valid(fetch_valid),
    .running    (running),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        reload;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_ready;
    logic        e_run;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reload     = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 32'h0;
    ld_last    = 1'b0;
    cpu_stall  = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    jmp        = 1'b0;
    jmp_target = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard: each observed write must match the oldest expected write
  task automatic sb_sample();
    logic [63:0] e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", imem_addr, e[63:32]);
        chk("sb_data", imem_wdata, e[31:0]);
      end
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l, input logic rl,
                              input logic st, input logic b, input logic [31:0] bt, input logic j,
                              input logic [31:0] jt, input logic we, input logic [31:0] ad,
                              input logic rdy, input logic run, input logic [31:0] p);
    vec_t r;
    r = '{v, d, l, rl, st, b, bt, j, jt, we, ad, rdy, run, p};
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //          vld d             lst rl  st  br  br_tgt        jmp jmp_tgt       we  addr          rdy run pc
    vecs[0]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h000,     1, 0, 32'h000);
    vecs[1]  = mk(1, 32'h20080005, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h000,     1, 0, 32'h000);
    vecs[2]  = mk(0, 32'hDEAD0001, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h004,     1, 0, 32'h000);
    vecs[3]  = mk(0, 32'hDEAD0002, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h004,     1, 0, 32'h000);
    vecs[4]  = mk(1, 32'h20090003, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h004,     1, 0, 32'h000);
    vecs[5]  = mk(1, 32'h01095020, 1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h008,     1, 0, 32'h000);
    vecs[6]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h000,     0, 1, 32'h000);
    vecs[7]  = mk(1, 32'h55555555, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h004,     0, 1, 32'h004);
    vecs[8]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h008,     0, 1, 32'h008);
    vecs[9]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h00C,     0, 1, 32'h00C);
    vecs[10] = mk(0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h010,     0, 1, 32'h010);
    vecs[11] = mk(0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h010,     0, 1, 32'h010);
    vecs[12] = mk(0, 32'h0,        0, 0, 1, 1, 32'h100,      1, 32'h43,       0, 32'h010,     0, 1, 32'h010);
    vecs[13] = mk(0, 32'h0,        0, 0, 0, 1, 32'h1234,     0, 32'h0,        0, 32'h040,     0, 1, 32'h040);
    vecs[14] = mk(0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h234,     0, 1, 32'h234);
    vecs[15] = mk(1, 32'hAAAA5555, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h000,     1, 0, 32'h000);
    vecs[16] = mk(1, 32'h12345678, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h004,     1, 0, 32'h000);
    vecs[17] = mk(1, 32'hBBBB0000, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h000,     1, 0, 32'h000);
    vecs[18] = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h004,     1, 0, 32'h000);

    // reset values, checked while reset is held
    #2;
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_pc", pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // table-driven load / run / redirect / reload flow
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      ld_valid   = vecs[k].ld_valid;
      ld_data    = vecs[k].ld_data;
      ld_last    = vecs[k].ld_last;
      reload     = vecs[k].reload;
      cpu_stall  = vecs[k].stall;
      br_taken   = vecs[k].br;
      br_target  = vecs[k].br_tgt;
      jmp        = vecs[k].jmp;
      jmp_target = vecs[k].jmp_tgt;
      if (vecs[k].e_we) exp_q.push_back({vecs[k].e_addr, vecs[k].ld_data});
      #1;
      chk($sformatf("v%0d_we", k), 32'(imem_we), 32'(vecs[k].e_we));
      chk($sformatf("v%0d_addr", k), imem_addr, vecs[k].e_addr);
      chk($sformatf("v%0d_ready", k), 32'(ld_ready), 32'(vecs[k].e_ready));
      chk($sformatf("v%0d_running", k), 32'(running), 32'(vecs[k].e_run));
      chk($sformatf("v%0d_fetch_valid", k), 32'(fetch_valid), 32'(vecs[k].e_run));
      chk($sformatf("v%0d_pc", k), pc, vecs[k].e_pc);
      chk($sformatf("v%0d_pc_plus4", k), pc_plus4, (vecs[k].e_pc + 32'd4) & 32'h3FF);
      sb_sample();
    end

    // full memory load with no ld_last, then sequential run across the wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 32'hC0DE_0000 | 32'(i);
      exp_q.push_back({32'(i * 4), ld_data});
      #1;
      chk($sformatf("full_we_%0d", i), 32'(imem_we), 32'd1);
      sb_sample();
    end
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("full_running", 32'(running), 32'd1);
    chk("full_pc0", pc, 32'h000);
    repeat (254) @(negedge clk);
    #1;
    chk("wrap_pc_3f8", pc, 32'h3F8);
    @(negedge clk);
    #1;
    chk("wrap_pc_3fc", pc, 32'h3FC);
    chk("wrap_pc_plus4", pc_plus4, 32'h000);
    @(negedge clk);
    #1;
    chk("wrap_pc_000", pc, 32'h000);

    // asynchronous reset while running
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_run_running", 32'(running), 32'd0);
    chk("async_run_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset mid-load after two words
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 32'hFEED_0000 | 32'(i);
      exp_q.push_back({32'(i * 4), ld_data});
      #1;
      sb_sample();
    end
    @(negedge clk);
    ld_valid = 1'b0;
    #2;
    rst_n    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'h7777_0000;
    #1;
    chk("async_load_we", 32'(imem_we), 32'd0);
    chk("async_load_ready", 32'(ld_ready), 32'd1);
    chk("async_load_addr", imem_addr, 32'h0);
    chk("async_load_fetch_valid", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({32'h0, ld_data});
    #1;
    chk("after_reset_we", 32'(imem_we), 32'd1);
    sb_sample();
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("after_reset_addr", imem_addr, 32'h4);

    chk("sb_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Owns the single port of the 256-word instruction memory and decides who uses it.
- After reset it runs a LOAD phase: a host streams 32-bit instruction words through a valid/ready handshake, and they are written to sequential word addresses.
- It then switches to RUN, where it holds the program counter and drives the fetch address every cycle.
- Next-PC selection covers sequential, branch, jump and stall.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; power of two.
- RESET_PC, 32'h0000_0000, PC value on entering RUN; word-aligned and < DEPTH*4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reload  in  1  synchronous pulse; abandons RUN and re-enters LOAD.
- ld_valid  in  1  host has a word on ld_data.
- ld_ready  out  1  sequencer accepts a word this cycle.
- ld_data  in  32  instruction word to store.
- ld_last  in  1  qualifies an accepted word as the final one.
- cpu_stall  in  1  hold the PC (RUN only).
- br_taken  in  1  take br_target next cycle.
- br_target  in  32  branch byte address.
- jmp  in  1  take jmp_target next cycle.
- jmp_target  in  32  jump byte address.
- imem_we  out  1  memory write strobe.
- imem_addr  out  32  memory byte address; memory indexes by addr>>2.
- imem_wdata  out  32  memory write data.
- pc  out  32  current program counter.
- pc_plus4  out  32  pc+4, wrapped as below.
- fetch_valid  out  1  imem_addr is a legal fetch for the CPU this cycle.
- running  out  1  state is RUN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LOAD, wp=0, pc=RESET_PC.
  - Outputs during reset: ld_ready=1, imem_we=0, fetch_valid=0, running=0.
  - Reset asserted mid-load or mid-run discards all progress immediately; memory contents are not cleared.
- States: LOAD, RUN.
- LOAD:
  - ld_ready=1. Accept = ld_valid & ld_ready.
  - On accept, in the same cycle (combinational): imem_we=1, imem_addr={wp,2'b00} zero-extended, imem_wdata=ld_data.
  - wp increments at the clock edge.
  - When there is no accept: imem_we=0 and imem_addr={wp,2'b00}.
  - fetch_valid=0; pc holds RESET_PC.
- LOAD -> RUN:
  - Taken at the edge after an accept with ld_last=1, or an accept when wp==DEPTH-1 (memory full; an ld_last on that word is redundant).
  - wp returns to 0 and pc=RESET_PC.
  - ld_valid without accept never advances wp.
- RUN:
  - ld_ready=0, imem_we=0, imem_addr=pc, fetch_valid=1, running=1.
  - Next pc, in priority order:
    - reload: enter LOAD; pc=RESET_PC, wp=0.
    - jmp: jmp_target & ~3.
    - br_taken: br_target & ~3.
    - cpu_stall: pc holds.
    - otherwise: pc_plus4.
  - Jump and branch override stall.
- Wrap and width rules:
  - pc_plus4 = (pc+4) mod (DEPTH*4), so 4*(DEPTH-1) wraps to 0.
  - Targets are masked to word alignment and then reduced mod DEPTH*4; upper bits are dropped.
- reload in LOAD: restarts at wp=0 and ignores any simultaneous accept (no write).
- Latency:
  - Memory read is combinational, so an instruction is available in the same cycle as pc.
  - A redirect becomes visible on pc one cycle after the jmp/br_taken assertion.

Decomposition:
- Shared package constants: IMEM_DEPTH=256, WORD_BYTES=4, RESET_PC, and state encodings ST_LOAD/ST_RUN.
- One natural sub-module: imem_next_pc (purely combinational next-PC mux with alignment and wrap).
- The loader pointer and FSM stay in the top level.

Test Plan:
- Reset, then load 3 words (0x20080005, 0x20090003, 0x01095020) with ld_last on the third -> writes at 0x0, 0x4, 0x8 with imem_we=1 in each accept cycle; running=1 the next cycle with pc=0, followed by pc=4, 8, 0xC.
- ld_valid held low for 2 cycles between words -> no writes, wp unchanged; the second word lands at 0x4.
- Load all 256 words with no ld_last -> the 256th word is written at 0x3FC, then RUN; pc sequence 0x3F8 -> 0x3FC -> 0x000.
- In RUN at pc=0x10: cpu_stall=1 for 2 cycles -> pc stays 0x10 for 3 cycles. Then jmp=1, jmp_target=0x43, br_taken=1 together -> pc=0x40 (jump wins, aligned).
- In RUN: br_taken=1, br_target=0x1234 -> pc=0x234. Then reload pulse -> running=0, ld_ready=1, the next accepted word is written at 0x0.
- Assert rst_n=0 asynchronously mid-LOAD after 2 words -> outputs return to reset values without a clock edge; the next load starts at 0x0.
